fun_sweep_ctrl: RTL and testbench
=================================

# fun_sweep_ctrl

Sequencer that drives the 4-input dual-rail combinational function block through all 16 input combinations. For each vector it waits a programmable settle time, then samples the function output, builds a 16-bit truth table and checks it against an expected table. It sits between a host/test controller (start/done handshake) and the function block's `a, not_a … d, not_d` inputs and `out` output.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range is ≥1; 0 is illegal.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a sweep when idle.
- `abort`  in  1  cancels a sweep in progress.
- `expected`  in  16  golden truth table; latched on accepted `start`.
- `fun_out`  in  1  function block output.
- `vec`  out  4  `{a,b,c,d}`, with `a` as MSB; the value equals the current index.
- `vec_n`  out  4  bitwise complement of `vec`, driving `not_a..not_d`.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `truth_table`  out  16  bit i = `fun_out` sampled at index i.
- `mismatch`  out  1  at least one bit differed from `expected`.
- `fail_idx`  out  4  lowest index that mismatched.

## Operation
- **Reset values:** `vec`=0, `vec_n`=4'hF, `busy`=0, `done`=0, `truth_table`=0, `mismatch`=0, `fail_idx`=0. The FSM is in IDLE, `idx`=0, settle counter=0.
- **FSM states:** IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:**
  - `start`=1 and `abort`=0: latch `expected`, clear `truth_table`, `mismatch` and `fail_idx`, set `idx`=0 and counter=0, go to SETTLE.
  - `start` together with `abort` is ignored.
- **SETTLE:**
  - `vec`=`idx`, `vec_n`=~`idx`.
  - The counter increments each cycle. When counter==`SETTLE_CYCLES`-1, go to SAMPLE.
- **SAMPLE:**
  - `truth_table[idx]`<=`fun_out`.
  - If `fun_out`≠`expected_q[idx]` and `mismatch`=0: `mismatch`<=1 and `fail_idx`<=`idx`.
  - If `idx`==15, go to DONE. Otherwise `idx`++, counter<=0, go to SETTLE.
  - `vec` stays stable through SAMPLE.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE. `vec` returns to 0 in IDLE.
- `truth_table`, `mismatch` and `fail_idx` hold their values until the next accepted `start` or reset.
- **`start` while busy:** ignored. `expected` is not re-latched.
- **`abort` in SETTLE/SAMPLE:** next state is IDLE, `vec`=0, no `done` pulse. Partial `truth_table` and `mismatch` are retained.
- **`rst_n` low mid-sweep:** all registers take their reset values immediately, asynchronously.
- **Index wrap:** `idx` never wraps. The sweep terminates after index 15.

## Timing
- All outputs are registered. `vec`/`vec_n` change only on `clk` edges.
- Each vector occupies `SETTLE_CYCLES`+1 cycles: SETTLE_CYCLES settle cycles plus 1 sample cycle.
- `start` is sampled at edge k; `busy`=1 from edge k.
- `done` rises at edge k + 16·(`SETTLE_CYCLES`+1). For the default this is k+48.
- `done` is high for exactly one cycle. Back-to-back: `start` is accepted in the cycle after `done`.
- `fun_out` is sampled at the SAMPLE-cycle edge. The function block's combinational delay must be under `SETTLE_CYCLES`·Tclk.

## Structure
- **Shared package `fun_sweep_pkg`:**
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - `NUM_VARS`=4
  - `TT_WIDTH`=16
- **Sub-module `settle_timer`:** load/clear, count, and `expire` when count==`SETTLE_CYCLES`-1. Instantiated once.
- The FSM, index register and result registers live in the top-level module.
- The bench instantiates the existing function block and wires `vec[3]`→`a`, `vec_n[3]`→`not_a`, … , `vec[0]`→`d`.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs at reset values, `vec_n`=4'hF.
- **Full sweep with a model:** model f=(a&b)|(c&~d), `expected`=16'hF444, `start` pulse.
  - At k+48: `done`=1 and `truth_table`=16'hF444, `mismatch`=0.
  - Each vector is held 3 cycles, in order 0..15.
- **Mismatch:** same model with `expected`=16'hF440.
  - At done: `mismatch`=1, `fail_idx`=2.
  - A second bad bit at index 14 (`expected`=16'hB440) still gives `fail_idx`=2.
- **`start` while busy:** pulse `start` at cycle k+10 with a different `expected`.
  - The sweep completes at k+48, unchanged, with a single `done`.
- **Abort at k+20:**
  - `busy`=0 next cycle, `vec`=0, and no `done` within 60 cycles.
  - A new `start` then runs a full sweep correctly.
- **Async reset mid-sweep, then `SETTLE_CYCLES`=1 build:**
  - Reset at k+15 clears everything.
  - With `SETTLE_CYCLES`=1, a full sweep gives `done` at k+32.

Source files
------------

// File: rtl/fun_sweep_pkg.sv
// Shared definitions for the dual-rail function sweep controller.
//   NUM_VARS : number of function inputs (a..d)
//   TT_WIDTH : truth-table width, 2**NUM_VARS
//   state_t  : sequencer state encoding (IDLE, SETTLE, SAMPLE, DONE)
package fun_sweep_pkg;

    localparam int unsigned NUM_VARS = 4;
    localparam int unsigned TT_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SETTLE = 2'd1;
    localparam state_t S_SAMPLE = 2'd2;
    localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/fun_sweep_ctrl_if.sv
// Bundle between the host / function block and the sweep controller.
//   start, abort, expected : host controls (expected latched on accepted start)
//   fun_out                : function block output
//   vec, vec_n             : dual-rail drive of a..d / not_a..not_d (a is MSB)
//   busy, done             : sweep status, done is a one-cycle pulse
//   truth_table, mismatch, fail_idx : sweep result
// The controller uses the slave modport; the host/bench side uses master.
interface fun_sweep_ctrl_if;
    import fun_sweep_pkg::*;

    logic                start;
    logic                abort;
    logic [TT_WIDTH-1:0] expected;
    logic                fun_out;
    logic [NUM_VARS-1:0] vec;
    logic [NUM_VARS-1:0] vec_n;
    logic                busy;
    logic                done;
    logic [TT_WIDTH-1:0] truth_table;
    logic                mismatch;
    logic [NUM_VARS-1:0] fail_idx;

    modport master (
        output start, abort, expected, fun_out,
        input  vec, vec_n, busy, done, truth_table, mismatch, fail_idx
    );

    modport slave (
        input  start, abort, expected, fun_out,
        output vec, vec_n, busy, done, truth_table, mismatch, fail_idx
    );

endinterface

// File: rtl/fun_sweep_ctrl_settle_timer.sv
// Settle counter for one sweep vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : force count to zero (has priority over i_count)
//   i_count    : advance count by one
//   o_expire   : count has reached SETTLE_CYCLES-1
// SETTLE_CYCLES must be at least 1.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_expire = (r_cnt == LastCnt);

endmodule

// File: rtl/fun_sweep_ctrl.sv
// Sweeps a 4-input dual-rail function block through all 16 input vectors,
// samples its output after a settle time and compares against a golden table.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fun_sweep_ctrl_if (host handshake, function
//                block drive/sense, results); all outputs are registered
module fun_sweep_ctrl
    import fun_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fun_sweep_ctrl_if.slave bus
);

    localparam logic [NUM_VARS-1:0] LastIdx = '1;

    state_t              r_state, w_state_d;
    logic [NUM_VARS-1:0] r_idx, w_idx_d;
    logic [NUM_VARS-1:0] r_vec, r_vec_n, w_vec_d;
    logic                r_busy, r_done;
    logic [TT_WIDTH-1:0] r_expected, r_tt;
    logic                r_mismatch;
    logic [NUM_VARS-1:0] r_fail_idx;

    logic w_accept, w_abort, w_sample, w_expire, w_tmr_clear, w_tmr_count;

    // start together with abort is not a valid request
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_abort  = bus.abort && ((r_state == S_SETTLE) || (r_state == S_SAMPLE));
    // an abort in the sample cycle pre-empts the sample
    assign w_sample = (r_state == S_SAMPLE) && !bus.abort;

    assign w_tmr_clear = w_accept || w_abort || (r_state == S_SAMPLE);
    assign w_tmr_count = (r_state == S_SETTLE) && !w_expire;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_tmr_clear),
        .i_count (w_tmr_count),
        .o_expire(w_expire)
    );

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_abort) begin
                    w_state_d = S_IDLE;
                end else if (w_expire) begin
                    w_state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_abort) begin
                    w_state_d = S_IDLE;
                end else if (r_idx == LastIdx) begin
                    w_state_d = S_DONE;
                end else begin
                    w_state_d = S_SETTLE;
                    w_idx_d   = r_idx + NUM_VARS'(1);
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
        if (w_state_d == S_IDLE) begin
            w_idx_d = '0;
        end
        // vec follows the index while a sweep is active and rests at 0 in IDLE
        w_vec_d = (w_state_d == S_IDLE) ? '0 : w_idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_vec      <= '0;
            r_vec_n    <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_expected <= '0;
            r_tt       <= '0;
            r_mismatch <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_vec   <= w_vec_d;
            r_vec_n <= ~w_vec_d;
            r_busy  <= (w_state_d == S_SETTLE) || (w_state_d == S_SAMPLE);
            r_done  <= (w_state_d == S_DONE);
            if (w_accept) begin
                r_expected <= bus.expected;
                r_tt       <= '0;
                r_mismatch <= 1'b0;
                r_fail_idx <= '0;
            end else if (w_sample) begin
                r_tt[r_idx] <= bus.fun_out;
                // indices ascend, so the first miss is the lowest one
                if ((bus.fun_out != r_expected[r_idx]) && !r_mismatch) begin
                    r_mismatch <= 1'b1;
                    r_fail_idx <= r_idx;
                end
            end
        end
    end

    assign bus.vec         = r_vec;
    assign bus.vec_n       = r_vec_n;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.truth_table = r_tt;
    assign bus.mismatch    = r_mismatch;
    assign bus.fail_idx    = r_fail_idx;

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Bench for fun_sweep_ctrl: one instance with the default settle time and one
// with SETTLE_CYCLES=1, each driving a behavioural dual-rail function block.
module tb_fun_sweep_ctrl;
    import fun_sweep_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        use_rand = 1'b0;
    logic [15:0] rand_tt  = '0;
    int          checks   = 0;
    int          errors   = 0;

    always #5 clk = ~clk;

    fun_sweep_ctrl_if bus_a ();
    fun_sweep_ctrl_if bus_b ();

    fun_sweep_ctrl #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fun_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Function block f = a&b | c&~d; ~d comes from the not_d rail.
    assign bus_a.fun_out = use_rand ? rand_tt[bus_a.vec]
                         : ((bus_a.vec[3] & bus_a.vec[2]) | (bus_a.vec[1] & bus_a.vec_n[0]));
    assign bus_b.fun_out = use_rand ? rand_tt[bus_b.vec]
                         : ((bus_b.vec[3] & bus_b.vec[2]) | (bus_b.vec[1] & bus_b.vec_n[0]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truth table the function block should produce over indices 0..15.
    function automatic logic [15:0] ref_table(input logic rnd, input logic [15:0] rt);
        logic [15:0] t;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            t[i] = rnd ? rt[i] : ((v[3] & v[2]) | (v[1] & ~v[0]));
        end
        return t;
    endfunction

    function automatic logic [3:0] ref_fail(input logic [15:0] got, input logic [15:0] exp);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (got[i] != exp[i]) r = 4'(i);
        end
        return r;
    endfunction

    // One sweep on dut_a. Edge k is the edge sampling start; c counts edges after k.
    task automatic sweep_a(input logic [15:0] exp, input logic [15:0] exp_late,
                           input int restart_at, input int abort_at,
                           output int done_at, output int n_done, output int seq_bad,
                           output logic busy_k, output logic busy_done,
                           output logic [4:0] ab_state);
        logic [3:0] vexp;
        bus_a.expected = exp;
        bus_a.start    = 1'b1;
        tick();
        busy_k         = bus_a.busy;
        bus_a.start    = 1'b0;
        bus_a.expected = exp_late;
        done_at   = -1;
        n_done    = 0;
        seq_bad   = 0;
        busy_done = 1'b1;
        ab_state  = '1;
        if (bus_a.vec !== 4'h0 || bus_a.vec_n !== 4'hF) seq_bad++;
        for (int c = 1; c <= 60; c++) begin
            bus_a.start = (c == restart_at);
            bus_a.abort = (c == abort_at);
            tick();
            if (bus_a.done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin
                    done_at   = c;
                    busy_done = bus_a.busy;
                end
            end
            if (c == abort_at) ab_state = {bus_a.busy, bus_a.vec};
            if (c < 48 && (abort_at < 0 || c < abort_at)) begin
                vexp = 4'(c / 3);
                if (bus_a.vec !== vexp || bus_a.vec_n !== ~vexp || bus_a.busy !== 1'b1) seq_bad++;
            end
        end
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
    endtask

    // One sweep on dut_b (one settle cycle); returns right after the done edge.
    task automatic sweep_b(input logic [15:0] exp, output int done_at, output int seq_bad);
        logic [3:0] vexp;
        bus_b.expected = exp;
        bus_b.start    = 1'b1;
        tick();
        bus_b.start    = 1'b0;
        bus_b.expected = ~exp;
        done_at = -1;
        seq_bad = (bus_b.vec !== 4'h0 || bus_b.busy !== 1'b1) ? 1 : 0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            tick();
            if (bus_b.done === 1'b1) begin
                done_at = c;
            end else if (c < 32) begin
                vexp = 4'(c / 2);
                if (bus_b.vec !== vexp || bus_b.vec_n !== ~vexp) seq_bad++;
            end
        end
    endtask

    initial begin
        int          done_at, n_done, seq_bad;
        logic        busy_k, busy_done;
        logic [4:0]  ab_state;
        logic [15:0] ref_tt, exp, rt;

        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.expected = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.expected = '0;

        // Reset values
        repeat (3) tick();
        check("reset_a", {1'b0, bus_a.vec, bus_a.vec_n, bus_a.busy, bus_a.done, bus_a.truth_table,
                          bus_a.mismatch, bus_a.fail_idx},
              {1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0});
        check("reset_b", {1'b0, bus_b.vec, bus_b.vec_n, bus_b.busy, bus_b.done, bus_b.truth_table,
                          bus_b.mismatch, bus_b.fail_idx},
              {1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0});
        rst_n = 1'b1;
        repeat (2) tick();

        // Full sweep, matching table
        ref_tt = ref_table(1'b0, 16'h0);
        sweep_a(16'hF444, ~16'hF444, -1, -1, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
        check("busy_at_start", 32'(busy_k), 32'd1);
        check("done_latency", 32'(done_at), 32'd48);
        check("single_done", 32'(n_done), 32'd1);
        check("vec_sequence", 32'(seq_bad), 32'd0);
        check("busy_at_done", 32'(busy_done), 32'd0);
        check("tt_full", 32'(bus_a.truth_table), 32'(ref_tt));
        check("mismatch_clean", 32'(bus_a.mismatch), 32'(ref_tt != 16'hF444));

        // Single and double mismatch
        sweep_a(16'hF440, 16'h0, -1, -1, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
        check("mm1_tt", 32'(bus_a.truth_table), 32'(ref_tt));
        check("mm1_flag", 32'(bus_a.mismatch), 32'd1);
        check("mm1_idx", 32'(bus_a.fail_idx), 32'(ref_fail(ref_tt, 16'hF440)));
        sweep_a(16'hB440, 16'hFFFF, -1, -1, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
        check("mm2_flag", 32'(bus_a.mismatch), 32'd1);
        check("mm2_idx", 32'(bus_a.fail_idx), 32'(ref_fail(ref_tt, 16'hB440)));

        // start while busy with a different expected table
        sweep_a(16'hF444, 16'h0000, 10, -1, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
        check("rebusy_done", 32'(done_at), 32'd48);
        check("rebusy_single", 32'(n_done), 32'd1);
        check("rebusy_mm", 32'(bus_a.mismatch), 32'd0);
        check("rebusy_tt", 32'(bus_a.truth_table), 32'(ref_tt));

        // Abort at k+20: vectors 0..5 were sampled, vector 6 was settling
        sweep_a(16'hF440, 16'h0, -1, 20, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
        check("abort_busy_vec", 32'(ab_state), 32'd0);
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_seq", 32'(seq_bad), 32'd0);
        check("abort_partial_tt", 32'(bus_a.truth_table), 32'({10'h0, ref_tt[5:0]}));
        check("abort_mm_kept", {27'h0, bus_a.mismatch, bus_a.fail_idx}, {27'h0, 1'b1, 4'd2});
        sweep_a(16'hF444, 16'h1234, -1, -1, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
        check("post_abort_done", 32'(done_at), 32'd48);
        check("post_abort_tt", 32'(bus_a.truth_table), 32'(ref_tt));
        check("post_abort_mm", 32'(bus_a.mismatch), 32'd0);

        // Asynchronous reset mid-sweep (bit 0 mismatches early)
        bus_a.expected = 16'hF445;
        bus_a.start    = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (15) tick();
        check("pre_reset_state", {30'h0, bus_a.busy, bus_a.mismatch}, {30'h0, 1'b1, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {1'b0, bus_a.vec, bus_a.vec_n, bus_a.busy, bus_a.done,
                              bus_a.truth_table, bus_a.mismatch, bus_a.fail_idx},
              {1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0});
        tick();
        rst_n = 1'b1;
        tick();

        // SETTLE_CYCLES=1 instance, back-to-back sweeps
        sweep_b(16'hF444, done_at, seq_bad);
        check("s1_done_latency", 32'(done_at), 32'd32);
        check("s1_vec_sequence", 32'(seq_bad), 32'd0);
        check("s1_tt", 32'(bus_b.truth_table), 32'(ref_tt));
        check("s1_mm", 32'(bus_b.mismatch), 32'd0);
        tick();
        sweep_b(16'hF440, done_at, seq_bad);
        check("s1_b2b_done", 32'(done_at), 32'd32);
        check("s1_b2b_mm", {27'h0, bus_b.mismatch, bus_b.fail_idx}, {27'h0, 1'b1, 4'd2});

        // Randomized function tables and expected tables
        use_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            rt  = 16'($urandom);
            exp = rt;
            if (t % 3 != 0) exp[$urandom_range(15, 0)] ^= 1'b1;
            if (t % 3 == 2) exp[$urandom_range(15, 0)] ^= 1'b1;
            rand_tt = rt;
            ref_tt  = ref_table(1'b1, rt);
            if (t < 3) begin
                sweep_a(exp, ~exp, -1, -1, done_at, n_done, seq_bad, busy_k, busy_done, ab_state);
                check("rnd_a_done", 32'(done_at), 32'd48);
                check("rnd_a_tt", 32'(bus_a.truth_table), 32'(ref_tt));
                check("rnd_a_res", {27'h0, bus_a.mismatch, bus_a.fail_idx},
                      {27'h0, (ref_tt != exp), ref_fail(ref_tt, exp)});
            end else begin
                sweep_b(exp, done_at, seq_bad);
                check("rnd_b_done", 32'(done_at), 32'd32);
                check("rnd_b_tt", 32'(bus_b.truth_table), 32'(ref_tt));
                check("rnd_b_res", {27'h0, bus_b.mismatch, bus_b.fail_idx},
                      {27'h0, (ref_tt != exp), ref_fail(ref_tt, exp)});
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
